branch_ctrl_unit: RTL

- Parametrised multi-cycle branch resolution unit for the LEGv8 control path. It generalises the fixed-width branch decode in controlUnit.
- Accepts one instruction per handshake and classifies it as B, BL, BR, CBZ, CBNZ, B.cond or non-branch.
- Fetches the register operand when needed, writes the link register for BL, and evaluates conditions against a latched NZCV register.
- Issues a one-cycle PC-select command to the PC unit.

---
 rtl/branch_ctrl_unit.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/branch_ctrl_unit.sv
// Multi-cycle LEGv8 branch resolution unit: classifies one instruction per handshake,
// fetches a register operand or writes the link register if needed, then issues a PC-select command.
module branch_ctrl_unit #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned LINK_REG = 30,
  parameter int unsigned COND_EN  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic [ADDR_W-1:0] pc,
  input  logic [3:0]        status_in,
  input  logic              status_we,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              reg_valid,
  output logic [4:0]        reg_rd_addr,
  output logic              reg_rd_en,
  output logic              link_we,
  output logic [4:0]        link_addr,
  output logic [ADDR_W-1:0] link_data,
  output logic [1:0]        pc_sel,
  output logic [ADDR_W-1:0] target,
  output logic              taken,
  output logic              done,
  output logic              busy
);

  localparam int unsigned REG_W = 5;
  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_PLUS4 = 2'd1;
  localparam logic [1:0] SEL_JUMP  = 2'd2;
  localparam logic [1:0] SEL_IN    = 2'd3;

  typedef enum logic [2:0] {IDLE, DECODE, OPREAD, LINK, RESOLVE} state_e;
  typedef enum logic [2:0] {C_NONE, C_B, C_BL, C_BCOND, C_CBZ, C_CBNZ, C_BR} cls_e;

  function automatic cls_e classify(input logic [31:0] w);
    cls_e c;
    c = C_NONE;
    if (w[31:26] == 6'b000101)                      c = C_B;
    else if (w[31:26] == 6'b100101)                 c = C_BL;
    else if (w[31:24] == 8'h54 && COND_EN != 0)     c = C_BCOND;
    else if (w[31:24] == 8'hB4)                     c = C_CBZ;
    else if (w[31:24] == 8'hB5)                     c = C_CBNZ;
    else if (w[31:21] == 11'b11010110000)           c = C_BR;
    return c;
  endfunction

  function automatic logic needs_reg(input cls_e c);
    return (c == C_CBZ) || (c == C_CBNZ) || (c == C_BR);
  endfunction

  // BR reads Rn, compare-and-branch reads Rt
  function automatic logic [REG_W-1:0] reg_idx(input logic [31:0] w, input cls_e c);
    return (c == C_BR) ? w[9:5] : w[4:0];
  endfunction

  // Word offset, sign-extended to the PC width
  function automatic logic [ADDR_W-1:0] rel_off(input logic [31:0] w, input logic long_imm);
    logic signed [27:0] o26;
    logic signed [20:0] o19;
    o26 = $signed({w[25:0], 2'b00});
    o19 = $signed({w[23:5], 2'b00});
    return long_imm ? ADDR_W'(o26) : ADDR_W'(o19);
  endfunction

  // f = {N,Z,C,V}; odd codes invert, except NV which is always taken like AL
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic r;
    unique case (c[3:1])
      3'd0:    r = f[2];
      3'd1:    r = f[1];
      3'd2:    r = f[3];
      3'd3:    r = f[0];
      3'd4:    r = f[1] & ~f[2];
      3'd5:    r = (f[3] == f[0]);
      3'd6:    r = ~f[2] & (f[3] == f[0]);
      default: r = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'd7) r = ~r;
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        flags_q, flags_d;
  logic [REG_W-1:0]  rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              link_we_q, link_we_d;
  logic [REG_W-1:0]  link_addr_q, link_addr_d;
  logic [ADDR_W-1:0] link_data_q, link_data_d;
  logic [1:0]        pc_sel_q, pc_sel_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              taken_q, taken_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  cls_e              cls_q_c, cls_in_c;
  logic              take_c;
  logic              resolve_c;
  logic [ADDR_W-1:0] pc_plus4_c;
  logic [ADDR_W-1:0] rel_tgt_c;

  assign cls_q_c    = classify(instr_q);
  assign cls_in_c   = classify(instr);
  assign pc_plus4_c = pc_q + ADDR_W'(4);
  assign rel_tgt_c  = pc_q + rel_off(instr_q, (cls_q_c == C_B) || (cls_q_c == C_BL));
  // A flag write in the cycle before RESOLVE is forwarded into the evaluation
  assign flags_d    = status_we ? status_in : flags_q;

  always_comb begin
    unique case (cls_q_c)
      C_B, C_BL: take_c = 1'b1;
      C_CBZ:     take_c = (reg_data == '0);
      C_CBNZ:    take_c = (reg_data != '0);
      C_BCOND:   take_c = cond_ok(instr_q[3:0], flags_d);
      default:   take_c = 1'b0;
    endcase
  end

  // Next-state and next-output logic; outputs land in registers as the state is entered
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = '0;
    link_we_d   = 1'b0;
    link_addr_d = '0;
    link_data_d = '0;
    pc_sel_d    = SEL_HOLD;
    target_d    = '0;
    taken_d     = 1'b0;
    done_d      = 1'b0;
    resolve_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          pc_d    = pc;
          state_d = DECODE;
          if (needs_reg(cls_in_c)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = reg_idx(instr, cls_in_c);
          end
        end
      end
      DECODE: begin
        if (cls_q_c == C_BL) begin
          state_d     = LINK;
          link_we_d   = 1'b1;
          link_addr_d = REG_W'(LINK_REG);
          link_data_d = pc_plus4_c;
        end else if (needs_reg(cls_q_c)) begin
          state_d   = OPREAD;
          rd_en_d   = 1'b1;
          rd_addr_d = reg_idx(instr_q, cls_q_c);
        end else begin
          state_d   = RESOLVE;
          resolve_c = 1'b1;
        end
      end
      OPREAD: begin
        if (reg_valid) begin
          state_d   = RESOLVE;
          resolve_c = 1'b1;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = reg_idx(instr_q, cls_q_c);
        end
      end
      LINK: begin
        state_d   = RESOLVE;
        resolve_c = 1'b1;
      end
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (resolve_c) begin
      done_d = 1'b1;
      if (cls_q_c == C_BR) begin
        pc_sel_d = SEL_IN;
        target_d = ADDR_W'(reg_data);
        taken_d  = 1'b1;
      end else if (take_c) begin
        pc_sel_d = SEL_JUMP;
        target_d = rel_tgt_c;
        taken_d  = 1'b1;
      end else begin
        pc_sel_d = SEL_PLUS4;
        target_d = pc_plus4_c;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      pc_q        <= '0;
      flags_q     <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      link_we_q   <= 1'b0;
      link_addr_q <= '0;
      link_data_q <= '0;
      pc_sel_q    <= SEL_HOLD;
      target_q    <= '0;
      taken_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      flags_q     <= flags_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      link_we_q   <= link_we_d;
      link_addr_q <= link_addr_d;
      link_data_q <= link_data_d;
      pc_sel_q    <= pc_sel_d;
      target_q    <= target_d;
      taken_q     <= taken_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign reg_rd_addr = rd_addr_q;
  assign reg_rd_en   = rd_en_q;
  assign link_we     = link_we_q;
  assign link_addr   = link_addr_q;
  assign link_data   = link_data_q;
  assign pc_sel      = pc_sel_q;
  assign target      = target_q;
  assign taken       = taken_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule
